key_expander: RTL

- Parametrised successor to the AES-128 key_generator.
- Supports AES-128, AES-192 and AES-256 (Nk = 4, 6 or 8 words), selected at elaboration.
- Iterative schedule: generates one 32-bit expanded word per clock into an internal word store.
- Serves any 128-bit round key by address to the cipher datapath, plus a start/busy/done handshake.

---
 rtl/key_expander.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/key_expander.sv
// Iterative AES-128/192/256 key schedule: one expanded word per clock into a word store,
// with any round key read combinationally by index. Define KEY_EXP_REVERSE_READ_EN to add read_reverse.
module key_expander #(
   parameter int KEY_WORDS = 4
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic                     start,
   input  logic [32*KEY_WORDS-1:0]  input_key,
   input  logic [3:0]               read_addr,
`ifdef KEY_EXP_REVERSE_READ_EN
   input  logic                     read_reverse,
`endif
   output logic [127:0]             round_key,
   output logic                     busy,
   output logic                     generation_done
);

   // state      | meaning
   // ST_IDLE    | nothing expanded since reset
   // ST_EXPAND  | writing one schedule word per clock
   // ST_DONE    | every round key valid; waiting for a new start

   localparam int NUM_ROUNDS  = KEY_WORDS + 6;
   localparam int TOTAL_WORDS = 4 * (NUM_ROUNDS + 1);

   if (!(KEY_WORDS == 4 || KEY_WORDS == 6 || KEY_WORDS == 8)) begin : g_bad_key_words
      $error("key_expander: KEY_WORDS must be 4, 6 or 8");
   end

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_DONE} state_t;

   state_t        state_q, state_d;
   logic [5:0]    idx_q, idx_d;
   logic [2:0]    mod_q, mod_d;
   logic [7:0]    rcon_q, rcon_d;
   logic [31:0]   words_q [TOTAL_WORDS];
   logic [31:0]   words_d [TOTAL_WORDS];
   logic          start_ok;
   logic          last_word;
   logic [31:0]   temp;
   logic [31:0]   new_word;
   logic [3:0]    eff_addr;
   logic          in_range;
   logic [5:0]    base;

   assign start_ok  = start && (state_q != ST_EXPAND);
   assign last_word = (idx_q == 6'(TOTAL_WORDS - 1));

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start_ok) state_d = ST_EXPAND;
         ST_EXPAND: if (last_word) state_d = ST_DONE;
         ST_DONE:   if (start_ok) state_d = ST_EXPAND;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy            = (state_q == ST_EXPAND);
      generation_done = (state_q == ST_DONE);
   end

   // i mod Nk comes from mod_q, a wrap counter running alongside idx_q.
   always_comb begin
      temp = words_q[idx_q - 6'd1];
      if (mod_q == 3'd0) begin
         temp = sub_word({temp[23:0], temp[31:24]}) ^ {rcon_q, 24'h0};
      end else if ((KEY_WORDS == 8) && (mod_q == 3'd4)) begin
         temp = sub_word(temp);
      end
      new_word = words_q[idx_q - 6'(KEY_WORDS)] ^ temp;

      words_d = words_q;
      idx_d   = idx_q;
      mod_d   = mod_q;
      rcon_d  = rcon_q;
      if (start_ok) begin
         for (int j = 0; j < KEY_WORDS; j++) begin
            words_d[j] = input_key[32*(KEY_WORDS-1-j) +: 32];
         end
         idx_d  = 6'(KEY_WORDS);
         mod_d  = 3'd0;
         rcon_d = 8'h01;
      end else if (state_q == ST_EXPAND) begin
         words_d[idx_q] = new_word;
         idx_d          = idx_q + 6'd1;
         mod_d          = (mod_q == 3'(KEY_WORDS - 1)) ? 3'd0 : mod_q + 3'd1;
         if (mod_q == 3'd0) rcon_d = xtime(rcon_q);
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         idx_q  <= '0;
         mod_q  <= '0;
         rcon_q <= '0;
         for (int j = 0; j < TOTAL_WORDS; j++) words_q[j] <= '0;
      end else begin
         idx_q   <= idx_d;
         mod_q   <= mod_d;
         rcon_q  <= rcon_d;
         words_q <= words_d;
      end
   end

   // Out-of-range addresses force base to 0 so the store is never indexed past its end.
   always_comb begin
      eff_addr = read_addr;
`ifdef KEY_EXP_REVERSE_READ_EN
      if (read_reverse) eff_addr = 4'(NUM_ROUNDS) - read_addr;
`endif
      in_range  = (read_addr <= 4'(NUM_ROUNDS));
      base      = in_range ? {eff_addr, 2'b00} : 6'd0;
      round_key = in_range ? {words_q[base], words_q[base + 6'd1],
                              words_q[base + 6'd2], words_q[base + 6'd3]} : 128'h0;
   end

endmodule
